// File: rtl/vx_barrier_unit.sv
// Warp barrier unit: parks arriving warps per barrier slot and emits one
// registered release mask when the last participant of a slot arrives.
module vx_barrier_unit #(
  parameter  int NUM_WARPS    = 4,
  parameter  int NUM_BARRIERS = 4,
  localparam int NW_BITS      = $clog2(NUM_WARPS),
  localparam int NB_BITS      = $clog2(NUM_BARRIERS)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 bar_valid,
  input  logic [NW_BITS-1:0]   bar_wid,
  input  logic [NB_BITS-1:0]   bar_id,
  input  logic [NW_BITS-1:0]   bar_size_m1,
  output logic                 bar_ready,
  output logic [NUM_WARPS-1:0] stalled_wmask,
  output logic                 rel_valid,
  output logic [NUM_WARPS-1:0] rel_wmask,
  input  logic                 rel_ready,
  output logic                 err_dup
);

  logic [NW_BITS-1:0]   slotCount_q [NUM_BARRIERS];
  logic [NW_BITS-1:0]   slotCount_d [NUM_BARRIERS];
  logic [NW_BITS-1:0]   slotSize_q  [NUM_BARRIERS];
  logic [NW_BITS-1:0]   slotSize_d  [NUM_BARRIERS];
  logic [NUM_WARPS-1:0] slotMask_q  [NUM_BARRIERS];
  logic [NUM_WARPS-1:0] slotMask_d  [NUM_BARRIERS];
  logic [NUM_BARRIERS-1:0] slotActive_q, slotActive_d;

  logic                 relValid_q, relValid_d;
  logic [NUM_WARPS-1:0] relMask_q, relMask_d;
  logic                 errDup_q, errDup_d;

  logic [NUM_WARPS-1:0] widOnehot;
  logic [NUM_WARPS-1:0] stalledMask;
  logic                 accept;
  logic                 isDup;
  logic                 arrive;
  logic                 completes;
  logic                 selActive;
  logic [NW_BITS-1:0]   selCount;
  logic [NW_BITS-1:0]   selSize;
  logic [NUM_WARPS-1:0] selMask;

  always_comb begin
    widOnehot          = '0;
    widOnehot[bar_wid] = 1'b1;
  end

  always_comb begin
    stalledMask = '0;
    for (int b = 0; b < NUM_BARRIERS; b++) begin
      stalledMask = stalledMask | slotMask_q[b];
    end
  end

  // Only an unaccepted pending release can stall new arrivals.
  assign bar_ready = !(relValid_q && !rel_ready);
  assign accept    = bar_valid && bar_ready;
  assign isDup     = |(stalledMask & widOnehot);
  assign arrive    = accept && !isDup;

  assign selActive = slotActive_q[bar_id];
  assign selCount  = slotCount_q[bar_id];
  assign selSize   = slotSize_q[bar_id];
  assign selMask   = slotMask_q[bar_id];

  // A size of one completes on first arrival without ever activating the slot.
  assign completes = selActive ? (selCount == selSize) : (bar_size_m1 == '0);

  always_comb begin
    slotCount_d  = slotCount_q;
    slotSize_d   = slotSize_q;
    slotMask_d   = slotMask_q;
    slotActive_d = slotActive_q;
    if (arrive) begin
      if (completes) begin
        slotActive_d[bar_id] = 1'b0;
        slotCount_d[bar_id]  = '0;
        slotMask_d[bar_id]   = '0;
      end else if (selActive) begin
        slotCount_d[bar_id]  = selCount + NW_BITS'(1);
        slotMask_d[bar_id]   = selMask | widOnehot;
      end else begin
        slotActive_d[bar_id] = 1'b1;
        slotSize_d[bar_id]   = bar_size_m1;
        slotCount_d[bar_id]  = NW_BITS'(1);
        slotMask_d[bar_id]   = widOnehot;
      end
    end
  end

  // A completion can only be accepted while any pending release is being
  // taken, so loading the new mask never overwrites an unconsumed one.
  always_comb begin
    relValid_d = relValid_q;
    relMask_d  = relMask_q;
    if (relValid_q && rel_ready) begin
      relValid_d = 1'b0;
      relMask_d  = '0;
    end
    if (arrive && completes) begin
      relValid_d = 1'b1;
      relMask_d  = selMask | widOnehot;
    end
    errDup_d = accept && isDup;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int b = 0; b < NUM_BARRIERS; b++) begin
        slotCount_q[b] <= '0;
        slotSize_q[b]  <= '0;
        slotMask_q[b]  <= '0;
      end
      slotActive_q <= '0;
      relValid_q   <= 1'b0;
      relMask_q    <= '0;
      errDup_q     <= 1'b0;
    end else begin
      slotCount_q  <= slotCount_d;
      slotSize_q   <= slotSize_d;
      slotMask_q   <= slotMask_d;
      slotActive_q <= slotActive_d;
      relValid_q   <= relValid_d;
      relMask_q    <= relMask_d;
      errDup_q     <= errDup_d;
    end
  end

  assign stalled_wmask = stalledMask;
  assign rel_valid     = relValid_q;
  assign rel_wmask     = relMask_q;
  assign err_dup       = errDup_q;

endmodule

// File: doc/vx_barrier_unit.md
VX_BARRIER_UNIT -- requirements
Module: VX_barrier_unit

Interface
REQ-001 SHALL have parameter NUM_WARPS, default 4, meaning warps per core (power of 2, >=2); NW_BITS = log2(NUM_WARPS).
REQ-002 SHALL have parameter NUM_BARRIERS, default 4, meaning barrier slots (power of 2, >=2); NB_BITS = log2(NUM_BARRIERS).
REQ-003 SHALL have port clk, input, 1, the single clock.
REQ-004 SHALL have port reset, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port bar_valid, input, 1, barrier arrival request from warp-control commit.
REQ-006 SHALL have port bar_wid, input, NW_BITS, arriving warp id.
REQ-007 SHALL have port bar_id, input, NB_BITS, barrier slot index.
REQ-008 SHALL have port bar_size_m1, input, NW_BITS, participating warp count minus one.
REQ-009 SHALL have port bar_ready, output, 1, request accepted when bar_valid && bar_ready.
REQ-010 SHALL have port stalled_wmask, output, NUM_WARPS, warps currently parked on any barrier.
REQ-011 SHALL have port rel_valid, output, 1, release event pending.
REQ-012 SHALL have port rel_wmask, output, NUM_WARPS, warps to resume.
REQ-013 SHALL have port rel_ready, input, 1, scheduler accepts release when rel_valid && rel_ready.
REQ-014 SHALL have port err_dup, output, 1, one-cycle pulse on rejected duplicate arrival.

Function
REQ-015 Per slot state SHALL be: count (NW_BITS), size_m1 (NW_BITS, latched on first arrival), wmask (NUM_WARPS), active (1).
REQ-016 bar_ready SHALL equal !(rel_valid && !rel_ready); no other backpressure.
REQ-017 Accepted arrival to inactive slot, size_m1 != 0: active<=1, size_m1<=bar_size_m1, count<=1, wmask<=onehot(bar_wid).
REQ-018 Accepted arrival to active slot with count != slot size_m1: count<=count+1, wmask |= onehot(bar_wid); incoming bar_size_m1 ignored.
REQ-019 Accepted arrival completing slot (active and count == slot size_m1, or inactive and bar_size_m1 == 0): next cycle rel_valid=1, rel_wmask = wmask | onehot(bar_wid); slot cleared (active, count, wmask = 0) same edge.
REQ-020 rel_valid/rel_wmask SHALL be registered; hold stable until rel_ready; clear on accept unless a new completion occurs the same cycle, in which case load new mask.
REQ-021 stalled_wmask SHALL be combinational OR of all slot wmasks; completing warp never appears in it.
REQ-022 Arrival from warp already set in any slot wmask SHALL be dropped (no state change) and err_dup pulses 1 cycle later.
REQ-023 Simultaneous accept of a release and a new arrival SHALL both take effect; a completing arrival reloads rel_* per REQ-020.
REQ-024 Latency: arrival at edge N -> stalled_wmask/rel_valid update visible after edge N; no combinational path bar_valid -> rel_valid.
REQ-025 Counter wrap SHALL be impossible: count <= size_m1 <= NUM_WARPS-1.
REQ-026 Slots SHALL be independent; different bar_id values never interact.

Reset
REQ-027 On reset low, asynchronously: all slots inactive, count=0, wmask=0, rel_valid=0, rel_wmask=0, err_dup=0; stalled_wmask=0, bar_ready=1.
REQ-028 Reset mid-barrier SHALL discard parked warps with no release event emitted.

Verification
REQ-029 Barrier 1, size_m1=2; warps 0,1,2 arrive cycles 0,1,2 with rel_ready=1 -> stalled_wmask 0001, 0011, then rel_valid=1, rel_wmask=0111, stalled_wmask=0000.
REQ-030 size_m1=0 from warp 3 -> next cycle rel_valid=1, rel_wmask=1000; stalled_wmask stays 0000.
REQ-031 rel_ready=0 after a completion -> bar_ready=0, rel_wmask held unchanged 5 cycles; rel_ready=1 -> rel_valid=0, bar_ready=1 next cycle.
REQ-032 Warp 2 parked on barrier 0 re-arrives on barrier 3 -> err_dup pulses 1 cycle, barrier 3 stays inactive, stalled_wmask=0100.
REQ-033 Barriers 0 and 1 interleaved (size_m1=1 each, warps 0,1 and 2,3) -> two releases, masks 0011 and 1100, in completion order.
REQ-034 Reset asserted with warps 0,1 parked -> stalled_wmask=0000, rel_valid=0 immediately; no release after deassertion.
